// File: rtl/seq_shift_unit.sv
// Iterative one-bit-per-clock shift unit for fixed-point scaling by powers of two.
// It reports the last bit shifted out and a sticky OR of all bits shifted out, so downstream logic can round.
module seq_shift_unit #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [1:0]         mode,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   o,
    output logic               lsb_out,
    output logic               sticky
);

    localparam logic [1:0] MODE_ASR = 2'b00;
    localparam logic [1:0] MODE_LSR = 2'b01;
    localparam logic [1:0] MODE_LSL = 2'b10;
    localparam logic [1:0] MODE_ROR = 2'b11;

    generate
        if (WIDTH < 2 || SHAMT_W != $clog2(WIDTH)) begin : g_param_check
            $error("seq_shift_unit: WIDTH must be >= 2 and SHAMT_W must equal clog2(WIDTH)");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t             state_reg;
    logic [WIDTH-1:0]   work_reg;
    logic [SHAMT_W-1:0] cnt_reg;
    logic [1:0]         mode_reg;
    logic               sticky_reg;

    logic [WIDTH-1:0]   shr_next;
    logic [WIDTH-1:0]   shl_next;
    logic [WIDTH-1:0]   work_next;
    logic               fill_bit;
    logic               out_bit;
    logic               sticky_next;

    // The bit entering at the MSB on a right step decides between arithmetic, logical and rotate.
    always_comb begin
        fill_bit = 1'b0;
        case (mode_reg)
            MODE_ASR: fill_bit = work_reg[WIDTH-1];
            MODE_ROR: fill_bit = work_reg[0];
            default:  fill_bit = 1'b0;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH - 1; gi++) begin : g_step
            assign shr_next[gi]   = work_reg[gi+1];
            assign shl_next[gi+1] = work_reg[gi];
        end
    endgenerate
    assign shr_next[WIDTH-1] = fill_bit;
    assign shl_next[0]       = 1'b0;

    assign work_next   = (mode_reg == MODE_LSL) ? shl_next : shr_next;
    assign out_bit     = (mode_reg == MODE_LSL) ? work_reg[WIDTH-1] : work_reg[0];
    // A rotated bit is not lost, so it never contributes to the sticky rounding flag.
    assign sticky_next = sticky_reg | (out_bit & (mode_reg != MODE_ROR));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg  <= ST_IDLE;
            work_reg   <= '0;
            cnt_reg    <= '0;
            mode_reg   <= MODE_ASR;
            sticky_reg <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            o          <= '0;
            lsb_out    <= 1'b0;
            sticky     <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        work_reg   <= a;
                        cnt_reg    <= shamt;
                        mode_reg   <= mode;
                        sticky_reg <= 1'b0;
                        busy       <= 1'b1;
                        if (shamt != '0) begin
                            state_reg <= ST_SHIFT;
                        end else begin
                            state_reg <= ST_DONE;
                            done      <= 1'b1;
                            o         <= a;
                            lsb_out   <= 1'b0;
                            sticky    <= 1'b0;
                        end
                    end
                end
                ST_SHIFT: begin
                    work_reg   <= work_next;
                    cnt_reg    <= cnt_reg - 1'b1;
                    sticky_reg <= sticky_next;
                    // Results are loaded on the final step so they are valid while done is high.
                    if (cnt_reg == SHAMT_W'(1)) begin
                        state_reg <= ST_DONE;
                        done      <= 1'b1;
                        o         <= work_next;
                        lsb_out   <= out_bit;
                        sticky    <= sticky_next;
                    end
                end
                ST_DONE: begin
                    state_reg <= ST_IDLE;
                    done      <= 1'b0;
                    busy      <= 1'b0;
                end
                default: begin
                    state_reg <= ST_IDLE;
                    done      <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_shift_unit.sv
// Self-checking bench for seq_shift_unit: directed vector table, multi-cycle corner cases,
// randomized operations against a behavioural model, and an 8-bit instance.
module tb_seq_shift_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] a;
    logic [4:0]  shamt;
    logic [1:0]  mode;
    logic        busy, done, lsb_out, sticky;
    logic [31:0] o;

    logic        start8;
    logic [7:0]  a8;
    logic [2:0]  shamt8;
    logic [1:0]  mode8;
    logic        busy8, done8, lsb_out8, sticky8;
    logic [7:0]  o8;

    int checks;
    int failures;

    seq_shift_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .shamt(shamt), .mode(mode),
        .busy(busy), .done(done), .o(o), .lsb_out(lsb_out), .sticky(sticky)
    );

    seq_shift_unit #(.WIDTH(8), .SHAMT_W(3)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .shamt(shamt8), .mode(mode8),
        .busy(busy8), .done(done8), .o(o8), .lsb_out(lsb_out8), .sticky(sticky8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Shift defined on whole words: shift the value by s, then read off the lost bits.
    function automatic void model(input int w, input logic [63:0] av, input int s, input int m,
                                  output logic [63:0] ro, output logic rl, output logic rs);
        logic [63:0] mask;
        logic [63:0] sx;
        mask = (64'd1 << w) - 64'd1;
        av   = av & mask;
        ro = 0; rl = 0; rs = 0;
        case (m)
            0: begin
                sx = av[w-1] ? (av | ~mask) : av;
                ro = 64'($signed(sx) >>> s) & mask;
            end
            1: ro = av >> s;
            2: ro = (av << s) & mask;
            default: ro = ((av >> s) | (av << (w - s))) & mask;
        endcase
        if (s != 0) begin
            if (m == 2) begin
                rl = av[w-s];
                rs = |(av >> (w - s));
            end else begin
                rl = av[s-1];
                rs = (m == 3) ? 1'b0 : |(av & ((64'd1 << s) - 64'd1));
            end
        end
    endfunction

    task automatic run_op(input logic [31:0] ta, input int ts, input int tm, input string name);
        logic [63:0] eo;
        logic el, es;
        int n;
        model(32, {32'd0, ta}, ts, tm, eo, el, es);
        a = ta; shamt = 5'(ts); mode = 2'(tm); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; a = $urandom; shamt = 5'($urandom); mode = 2'($urandom);
        n = 1;
        while (!done && n < 40) begin
            if (!busy) begin
                chk({name, "_busy"}, 64'(busy), 64'd1);
            end
            @(posedge clk); #1;
            n++;
        end
        chk({name, "_latency"}, 64'(n), 64'(ts + 1));
        chk({name, "_o"}, 64'(o), eo);
        chk({name, "_lsb"}, 64'(lsb_out), 64'(el));
        chk({name, "_sticky"}, 64'(sticky), 64'(es));
        @(posedge clk); #1;
        chk({name, "_done_pulse"}, {62'd0, done, busy}, 64'd0);
        chk({name, "_hold_o"}, 64'(o), eo);
        $display("op %s a=0x%08h shamt=%0d mode=%0d -> o=0x%08h lsb=%0b sticky=%0b cycles=%0d",
                 name, ta, ts, tm, o, lsb_out, sticky, n);
    endtask

    typedef struct {
        logic [31:0] a;
        int          s;
        int          m;
        logic [31:0] eo;
        logic        el;
        logic        es;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int cyc, done_cnt, done_at, n;
        logic [31:0] cap_o;
        logic cap_l, cap_s;

        checks = 0; failures = 0;
        rst_n = 1'b0; start = 1'b0; a = '0; shamt = '0; mode = '0;
        start8 = 1'b0; a8 = '0; shamt8 = '0; mode8 = '0;

        // Reset then idle
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", {o, 4'b0, busy, done, lsb_out, sticky}, 64'd0);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("idle_state", {o, 4'b0, busy, done, lsb_out, sticky}, 64'd0);
        $display("reset/idle o=0x%08h busy=%0b done=%0b", o, busy, done);

        // Directed vector table with hand-derived expectations
        vecs[0] = '{32'h8000_0013, 4, 0, 32'hF800_0001, 1'b0, 1'b1};
        vecs[1] = '{32'h8000_0001, 1, 2, 32'h0000_0002, 1'b1, 1'b1};
        vecs[2] = '{32'h0000_000F, 2, 1, 32'h0000_0003, 1'b1, 1'b1};
        vecs[3] = '{32'h0000_0001, 1, 3, 32'h8000_0000, 1'b1, 1'b0};
        vecs[4] = '{32'h1234_5678, 0, 2, 32'h1234_5678, 1'b0, 1'b0};
        vecs[5] = '{32'h8000_0000, 31, 0, 32'hFFFF_FFFF, 1'b0, 1'b0};
        for (int i = 0; i < 6; i++) begin
            a = vecs[i].a; shamt = 5'(vecs[i].s); mode = 2'(vecs[i].m); start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            n = 1;
            while (!done && n < 40) begin
                @(posedge clk); #1;
                n++;
            end
            chk($sformatf("vec%0d_latency", i), 64'(n), 64'(vecs[i].s + 1));
            chk($sformatf("vec%0d_o", i), 64'(o), 64'(vecs[i].eo));
            chk($sformatf("vec%0d_lsb", i), 64'(lsb_out), 64'(vecs[i].el));
            chk($sformatf("vec%0d_sticky", i), 64'(sticky), 64'(vecs[i].es));
            $display("vec%0d a=0x%08h shamt=%0d mode=%0d -> o=0x%08h lsb=%0b sticky=%0b cycles=%0d",
                     i, vecs[i].a, vecs[i].s, vecs[i].m, o, lsb_out, sticky, n);
            @(posedge clk); #1;
        end

        // Start while busy is ignored
        a = 32'hFFFF_0000; shamt = 5'd31; mode = 2'b01; start = 1'b1;
        @(posedge clk); #1;
        cyc = 1; done_cnt = 0; done_at = -1; cap_o = '0; cap_l = 0; cap_s = 0;
        while (cyc <= 40) begin
            if (done) begin
                done_cnt++;
                done_at = cyc;
                cap_o = o; cap_l = lsb_out; cap_s = sticky;
            end
            if (cyc == 3) begin
                start = 1'b1; a = 32'h1; shamt = 5'd0;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        chk("busy_ignore_done_count", 64'(done_cnt), 64'd1);
        chk("busy_ignore_done_cycle", 64'(done_at), 64'd32);
        chk("busy_ignore_o", 64'(cap_o), 64'h1);
        chk("busy_ignore_flags", {62'd0, cap_l, cap_s}, 64'd3);
        $display("start-while-busy done_count=%0d done_cycle=%0d o=0x%08h", done_cnt, done_at, cap_o);

        // Reset mid-operation
        a = 32'hDEAD_BEEF; shamt = 5'd20; mode = 2'b00; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("midreset_state", {o, 4'b0, busy, done, lsb_out, sticky}, 64'd0);
        done_cnt = 0;
        repeat (25) begin
            @(posedge clk); #1;
            if (done || busy) done_cnt++;
        end
        chk("midreset_no_done", 64'(done_cnt), 64'd0);
        $display("mid-op reset busy=%0b o=0x%08h spurious=%0d", busy, o, done_cnt);
        run_op(32'hC000_0005, 3, 0, "after_reset");

        // Randomized operations against the model
        for (int i = 0; i < 40; i++) begin
            run_op($urandom, int'($urandom_range(0, 31)), int'($urandom_range(0, 3)),
                   $sformatf("rand%0d", i));
        end

        // 8-bit instance
        a8 = 8'h81; shamt8 = 3'd7; mode8 = 2'b00; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        n = 1;
        while (!done8 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("w8_latency", 64'(n), 64'd8);
        chk("w8_o", 64'(o8), 64'hFF);
        chk("w8_flags", {62'd0, lsb_out8, sticky8}, 64'd1);
        $display("w8 a=0x81 shamt=7 mode=0 -> o=0x%02h lsb=%0b sticky=%0b cycles=%0d",
                 o8, lsb_out8, sticky8, n);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
